// File: rtl/serial_adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_seq_pkg
// Description : Shared definitions for the bit-serial adder: FSM state
//               encodings and the legal operand-width range with its check.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_seq_pkg;

    // FSM encodings; 2'd3 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int c_width_min = 2;
    localparam int c_width_max = 32;

    function automatic bit width_legal(input int w);
        return (w >= c_width_min) && (w <= c_width_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_cell
// Description : Combinational one-bit full adder composed of two half adders
//               and an OR on their carries.
// Ports       : i_a, i_b    - operand bits
//               i_cin       - carry in
//               o_sum       - sum bit
//               o_cout      - carry out (majority of the three inputs)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_sum0;
    logic w_carry0;
    logic w_carry1;

    half_adder u_ha0 (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_sum0),
        .o_carry (w_carry0)
    );

    half_adder u_ha1 (
        .i_a     (w_sum0),
        .i_b     (i_cin),
        .o_sum   (o_sum),
        .o_carry (w_carry1)
    );

    // The two half-adder carries can never both be set, so OR is exact.
    assign o_cout = w_carry0 | w_carry1;

endmodule
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module      : half_adder
// Description : One-bit half adder (sum = a ^ b, carry = a & b).
// Ports       : i_a, i_b    - addend bits
//               o_sum       - sum bit
//               o_carry     - carry bit
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule
`default_nettype wire

// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_seq
// Description : Bit-serial WIDTH-bit unsigned adder. Operands are captured on
//               an accepted start and added one bit per clock, LSB first,
//               through a single full-adder slice with a registered carry.
// Ports       : clk    - rising-edge clock
//               rst    - synchronous active-high reset
//               start  - request pulse, honoured in IDLE or DONE
//               A, B   - operands, captured on an accepted start
//               busy   - high while bits are being processed
//               done   - one-cycle pulse when S/C carry a new result
//               S, C   - sum and carry-out of the last completed operation
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("serial_adder_seq: WIDTH=%0d outside %0d..%0d",
               WIDTH, c_width_min, c_width_max);
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_c;

    logic             w_sum_bit;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    full_adder_cell u_fa (
        .i_a    (r_sh_a[0]),
        .i_b    (r_sh_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum_bit),
        .o_cout (w_cout)
    );

    // New sum bits enter at the MSB so that after WIDTH shifts bit 0 of the
    // result lines up with bit 0 of the operands.
    assign w_res_next = {w_sum_bit, r_res[WIDTH-1:1]};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts start exactly like IDLE, allowing
                    // back-to-back operations.
                    if (start) begin
                        r_state <= ST_RUN;
                        r_sh_a  <= A;
                        r_sh_b  <= B;
                        r_res   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
                    r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_s     <= w_res_next;
                        r_c     <= w_cout;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign S    = r_s;
    assign C    = r_c;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_seq
// Description : Self-checking bench for serial_adder_seq at WIDTH=8 and
//               WIDTH=16: directed vector table, multi-cycle corner cases and
//               a random regression, with a queue of expected {C,S} results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        st8, st16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, c8;
    logic [7:0]  s8;
    logic        busy16, done16, c16;
    logic [15:0] s16;

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .S(s8), .C(c8)
    );

    serial_adder_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .S(s16), .C(c16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [16:0] exp_q8[$];
    logic [16:0] exp_q16[$];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one start pulse and record the expected {C,S}.
    task automatic issue(input int w, input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1;
            exp_q8.push_back(17'(a[7:0]) + 17'(b[7:0]));
        end else begin
            a16 = a; b16 = b; st16 = 1'b1;
            exp_q16.push_back(17'(a) + 17'(b));
        end
        tick();
        st8 = 1'b0; st16 = 1'b0;
    endtask

    function automatic logic cur_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    // Wait (bounded) for done, then pop the scoreboard and compare.
    task automatic wait_done(input int w, output int n);
        logic [16:0] got, exp;
        n = 0;
        while (!cur_done(w) && n < 64) begin
            tick();
            n++;
        end
        if (!cur_done(w)) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout_w%0d: no done after %0d cycles, required within 64", w, n);
        end else begin
            got = (w == 8) ? {8'h00, c8, s8} : {c16, s16};
            if (w == 8 && exp_q8.size() == 0 || w == 16 && exp_q16.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done_w%0d: got result 0x%0h, required no done", w, got);
            end else begin
                exp = (w == 8) ? exp_q8.pop_front() : exp_q16.pop_front();
                check($sformatf("sum_w%0d", w), 32'(got), 32'(exp));
            end
        end
    endtask

    vec_t vecs[4];

    initial begin
        int n;
        logic ok;
        int dones;
        int last_done;

        vecs[0] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};

        rst = 1'b1; st8 = 1'b0; st16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_s",    32'(s8),    32'd0);
        check("reset_c",    32'(c8),    32'd0);
        check("reset_busy16", 32'(busy16), 32'd0);

        // Directed table: busy for 8 cycles, done in cycle k+9, one-cycle pulse.
        foreach (vecs[i]) begin
            issue(8, 16'(vecs[i].a), 16'(vecs[i].b));
            ok = 1'b1;
            for (int j = 0; j < 8; j++) begin
                ok &= busy8 & ~done8;
                tick();
            end
            check($sformatf("vec%0d_busy_window", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_busy_at_done", i), 32'(busy8), 32'd0);
            check($sformatf("vec%0d_table_sum", i), 32'({c8, s8}), 32'({vecs[i].c, vecs[i].s}));
            wait_done(8, n);
            check($sformatf("vec%0d_done_cycle", i), 32'(n), 32'd0);
            tick();
            check($sformatf("vec%0d_done_pulse", i), 32'(done8), 32'd0);
            check($sformatf("vec%0d_s_hold", i), 32'({c8, s8}), 32'({vecs[i].c, vecs[i].s}));
        end

        // start asserted mid-RUN with different operands must be ignored.
        issue(8, 16'h000F, 16'h0001);
        tick(); tick();
        a8 = 8'hFF; b8 = 8'hFF; st8 = 1'b1;
        check("midrun_s_stable", 32'(s8), 32'(vecs[3].s));
        tick(); tick();
        st8 = 1'b0;
        wait_done(8, n);
        check("midrun_latency", 32'(n), 32'd4);
        check("midrun_s", 32'(s8), 32'h10);
        tick();
        dones = 0;
        ok = 1'b1;
        for (int j = 0; j < 12; j++) begin
            dones += int'(done8);
            ok &= ~busy8;
            tick();
        end
        check("midrun_no_extra_done", 32'(dones), 32'd0);
        check("midrun_no_restart", 32'(ok), 32'd1);

        // start held across the DONE cycle starts the next op immediately.
        issue(8, 16'h0005, 16'h0006);
        wait_done(8, n);
        issue(8, 16'h0003, 16'h0004);
        check("b2b_restarted", 32'(busy8), 32'd1);
        wait_done(8, n);
        check("b2b_spacing", 32'(n + 1), 32'd9);
        check("b2b_s", 32'(s8), 32'h07);

        // Reset in RUN cycle 4 aborts with no done and clears S/C.
        issue(8, 16'h00F0, 16'h0020);
        void'(exp_q8.pop_back());
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_s", 32'(s8), 32'd0);
        check("abort_c", 32'(c8), 32'd0);
        dones = 0;
        for (int j = 0; j < 12; j++) begin
            dones += int'(done8);
            tick();
        end
        check("abort_no_done", 32'(dones), 32'd0);

        // Random regression on both widths, with random idle gaps (incl. none).
        for (int w = 8; w <= 16; w += 8) begin
            last_done = -1;
            for (int i = 0; i < 1000; i++) begin
                issue(w, 16'($urandom), 16'($urandom));
                wait_done(w, n);
                if (last_done >= 0)
                    check($sformatf("spacing_ok_w%0d", w),
                          32'(cyc - last_done >= w + 1), 32'd1);
                last_done = cyc;
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            end
        end

        check("queue8_empty",  32'(exp_q8.size()),  32'd0);
        check("queue16_empty", 32'(exp_q16.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial N-bit adder built around the team's half-adder datapath.
- Accepts two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, using a registered carry.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of the half-adder cell: two half adders plus an OR form the per-bit full-add, and this block sequences them over time.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; captured on an accepted start.
- B  input  WIDTH  operand B; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; S/C valid and new.
- S  output  WIDTH  sum of last completed operation; held until next completion.
- C  output  1  carry-out of last completed operation; held.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, S=0, C=0, state=IDLE. Internal operand/result shift registers, carry flop and counter are all cleared.
- States:
  - IDLE: start=1 -> RUN. Load shA<=A, shB<=B, carry<=0, cnt<=0, result shift reg<=0.
  - RUN: each edge:
    - sum_bit = shA[0]^shB[0]^carry.
    - carry <= majority(shA[0], shB[0], carry).
    - shA, shB shift right by 1.
    - result shifts right with sum_bit entering at MSB.
    - cnt++.
  - RUN exit: on the edge where cnt==WIDTH-1 (the last bit), go to DONE. Write S <= final result (including this bit) and C <= final carry.
  - DONE: lasts exactly one cycle; done=(state==DONE). start=1 here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- Latency: start sampled at edge k; busy high during cycles k+1..k+WIDTH; done high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while in RUN: ignored; no restart, operands not recaptured.
- A/B changes after capture: no effect on the operation in flight.
- S/C: change only at completion, never mid-operation. Between completions they hold the previous result.
- Arithmetic: {C,S} == A+B modulo 2^(WIDTH+1), i.e. exact unsigned sum.
- rst during RUN or DONE: aborts next edge to IDLE with all reset values. done is not pulsed; S/C are cleared.
- rst and start in the same cycle: rst wins.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 illegal -> IDLE);
  - the WIDTH range check.
- One sub-module: full_adder_cell, the combinational per-bit add built from two half-adder instances plus the carry OR. It is instantiated once for the serial bit slice.
- Counter, shift registers and FSM stay in serial_adder_seq.

Test Plan:
- Reset, then A=8'h00, B=8'h00, start pulse at edge k -> busy for 8 cycles; done exactly in cycle k+9; S=8'h00, C=0.
- A=8'hFF, B=8'h01 -> S=8'h00, C=1. A=8'hA5, B=8'h5A -> S=8'hFF, C=0. A=8'h80, B=8'h80 -> S=8'h00, C=1.
- Operation in flight (A=8'h0F, B=8'h01); assert start with A=8'hFF, B=8'hFF mid-RUN -> ignored; result S=8'h10, C=0; no early or extra done.
- start held high across the DONE cycle with new operands 8'h03+8'h04 -> second run starts immediately; second done 9 cycles after the first; S=8'h07.
- rst asserted at cycle 4 of RUN -> next cycle busy=0, S=0, C=0; done never pulses for the aborted operation.
- Random regression of 1000 operand pairs with WIDTH=8 and WIDTH=16 -> {C,S}==A+B at every done; done spacing is at least WIDTH+1 cycles.
